oq_hdr_parser_mc: RTL and testbench
===================================

OQ_HDR_PARSER_MC -- requirements
Module: oq_hdr_parser_mc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, datapath width in bits.
REQ-002 The block SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, control bus width.
REQ-003 The block SHALL have parameter IOQ_STAGE_NUM, default 8'hFF, in_ctrl value that marks the IOQ module header word.
REQ-004 The block SHALL have parameter NUM_OUTPUT_QUEUES, default 8, range 2..32, power of two; NUM_OQ_WIDTH = log2(NUM_OUTPUT_QUEUES).
REQ-005 The block SHALL have parameters DST_PORT_POS/BYTE_LEN_POS/WORD_LEN_POS, defaults 48/0/32, bit offsets of the header fields.
REQ-006 The block SHALL have parameter MAX_PKT, default 2048; PKT_BYTE_CNT_WIDTH = log2(MAX_PKT), PKT_WORD_CNT_WIDTH = log2(MAX_PKT/CTRL_WIDTH).
REQ-007 The block SHALL have parameter FIFO_DEPTH_BITS, default 3; descriptor FIFO depth = 2**FIFO_DEPTH_BITS.
REQ-008 Ports: clk in 1, clock; reset in 1, reset; in_wr in 1, word strobe; in_ctrl in CTRL_WIDTH; in_data in DATA_WIDTH.
REQ-009 Ports: rd_dst_oq in 1, pop descriptor; dst_oq_avail out 1, FIFO non-empty; header_parser_rdy out 1, FIFO not full.
REQ-010 Ports: parsed_dst_oq out NUM_OQ_WIDTH, lowest set queue index; parsed_dst_mask out NUM_OUTPUT_QUEUES, raw one-hot/multi-hot mask; parsed_multicast out 1, more than one mask bit set.
REQ-011 Ports: parsed_pkt_byte_len out PKT_BYTE_CNT_WIDTH; parsed_pkt_word_len out PKT_WORD_CNT_WIDTH; fifo_depth out FIFO_DEPTH_BITS+1, occupancy.
REQ-012 Ports: err_no_hdr out 1, pulse; err_overflow out 1, pulse.
REQ-013 Reset is named reset, synchronous, active-high; the clock is named clk.

Function
REQ-014 The state machine SHALL have states WAIT_HDR, WAIT_DATA, WAIT_EOP.
REQ-015 In WAIT_HDR, in_wr with in_ctrl==IOQ_STAGE_NUM SHALL push one descriptor and move to WAIT_DATA; other nonzero in_ctrl SHALL be ignored.
REQ-016 In WAIT_HDR, in_wr with in_ctrl==0 SHALL pulse err_no_hdr for one cycle and remain in WAIT_HDR.
REQ-017 In WAIT_DATA, in_wr with in_ctrl==0 SHALL move to WAIT_EOP; in WAIT_EOP, in_wr with in_ctrl!=0 SHALL move to WAIT_HDR.
REQ-018 Descriptor = {word_len, byte_len, mask, lowest-set index, multicast}, taken from in_data fields of the header word.
REQ-019 A mask of zero SHALL yield parsed_dst_oq=0, parsed_multicast=0, and the mask is passed through unchanged.
REQ-020 The FIFO SHALL be fall-through: a descriptor written in cycle N SHALL appear on the outputs with dst_oq_avail=1 in cycle N+1.
REQ-021 A push SHALL be accepted only when the FIFO is not full, regardless of rd_dst_oq in the same cycle.
REQ-022 A push while full SHALL drop the descriptor and pulse err_overflow, and the state SHALL still advance to WAIT_DATA.
REQ-023 rd_dst_oq while empty SHALL be ignored; simultaneous push and pop when non-empty SHALL leave fifo_depth unchanged.
REQ-024 Read and write pointers SHALL wrap modulo 2**FIFO_DEPTH_BITS.

Reset
REQ-025 On reset, state = WAIT_HDR, FIFO empty, fifo_depth=0, dst_oq_avail=0, header_parser_rdy=1, err pulses=0, parsed_* outputs = 0.
REQ-026 Reset asserted mid-packet SHALL discard all queued descriptors, and the next word SHALL be parsed in WAIT_HDR.

Configuration
REQ-027 With OQ_HDR_PARSER_ERR_CNT_EN defined, the block SHALL add outputs no_hdr_cnt and overflow_cnt (16 bits each), saturating at 16'hFFFF and cleared by reset.
REQ-028 Without OQ_HDR_PARSER_ERR_CNT_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Header with dst mask 8'h10, byte_len 60, word_len 8 -> the next cycle gives dst_oq_avail=1, parsed_dst_oq=4, parsed_multicast=0, byte/word length 60/8.
REQ-030 Header with mask 8'h24 -> parsed_dst_oq=2, parsed_multicast=1, parsed_dst_mask=8'h24.
REQ-031 9 packets with no reads at depth 8 -> header_parser_rdy=0 after the 8th packet, and the 9th packet gives a single err_overflow pulse with fifo_depth=8.
REQ-032 Data word (in_ctrl=0) while in WAIT_HDR -> one err_no_hdr pulse, and no descriptor is pushed.
REQ-033 With FIFO depth 3, header push and rd_dst_oq in the same cycle -> fifo_depth stays 3, and the output advances to the next descriptor.
REQ-034 Reset asserted in WAIT_EOP with 2 descriptors queued -> the next cycle shows dst_oq_avail=0, fifo_depth=0, and a following header is accepted.

Source files
------------

// File: rtl/oq_hdr_parser_mc.sv
// oq_hdr_parser_mc
//   Watches the packet stream entering the output-queue stage. Each IOQ
//   module header word is decoded into a descriptor {word length, byte
//   length, destination mask, lowest destination queue, multicast flag}.
//   The descriptor is pushed into a small fall-through FIFO, which the
//   queue manager pops.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_wr               word strobe for in_ctrl/in_data
//   in_ctrl, in_data    packet stream (ctrl==IOQ_STAGE_NUM marks the header)
//   rd_dst_oq           pop the head descriptor (ignored while empty)
//   dst_oq_avail        FIFO holds at least one descriptor
//   header_parser_rdy   FIFO is not full
//   parsed_dst_oq       lowest set queue index of the head descriptor
//   parsed_dst_mask     raw destination mask of the head descriptor
//   parsed_multicast    more than one destination bit set
//   parsed_pkt_byte_len / parsed_pkt_word_len   packet lengths
//   fifo_depth          FIFO occupancy
//   err_no_hdr          one-cycle pulse: data word seen while expecting a header
//   err_overflow        one-cycle pulse: header dropped because FIFO was full
//
// Build option
//   OQ_HDR_PARSER_ERR_CNT_EN adds 16-bit saturating counters no_hdr_cnt
//   and overflow_cnt that count the two error pulses.
module oq_hdr_parser_mc #(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int IOQ_STAGE_NUM     = 8'hFF,
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int DST_PORT_POS      = 48,
    parameter int BYTE_LEN_POS      = 0,
    parameter int WORD_LEN_POS      = 32,
    parameter int MAX_PKT           = 2048,
    parameter int FIFO_DEPTH_BITS   = 3,
    localparam int NUM_OQ_WIDTH       = $clog2(NUM_OUTPUT_QUEUES),
    localparam int PKT_BYTE_CNT_WIDTH = $clog2(MAX_PKT),
    localparam int PKT_WORD_CNT_WIDTH = $clog2(MAX_PKT / CTRL_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_wr,
    input  logic [CTRL_WIDTH-1:0]         in_ctrl,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          rd_dst_oq,
    output logic                          dst_oq_avail,
    output logic                          header_parser_rdy,
    output logic [NUM_OQ_WIDTH-1:0]       parsed_dst_oq,
    output logic [NUM_OUTPUT_QUEUES-1:0]  parsed_dst_mask,
    output logic                          parsed_multicast,
    output logic [PKT_BYTE_CNT_WIDTH-1:0] parsed_pkt_byte_len,
    output logic [PKT_WORD_CNT_WIDTH-1:0] parsed_pkt_word_len,
    output logic [FIFO_DEPTH_BITS:0]      fifo_depth,
`ifdef OQ_HDR_PARSER_ERR_CNT_EN
    output logic [15:0]                   no_hdr_cnt,
    output logic [15:0]                   overflow_cnt,
`endif
    output logic                          err_no_hdr,
    output logic                          err_overflow
);

    localparam int DESC_W = PKT_WORD_CNT_WIDTH + PKT_BYTE_CNT_WIDTH
                          + NUM_OUTPUT_QUEUES + NUM_OQ_WIDTH + 1;
    localparam int FIFO_ENTRIES = 2 ** FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] FULL_LVL = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};

    typedef enum logic [1:0] {WAIT_HDR, WAIT_DATA, WAIT_EOP} state_t;

    state_t                       state_reg;
    logic [FIFO_DEPTH_BITS-1:0]   wr_ptr_reg;
    logic [FIFO_DEPTH_BITS-1:0]   rd_ptr_reg;
    logic [FIFO_DEPTH_BITS:0]     depth_reg;
    logic                         err_no_hdr_reg;
    logic                         err_overflow_reg;
    logic [DESC_W-1:0]            desc_mem [FIFO_ENTRIES];

    // ---------------- header field decode ----------------
    logic [NUM_OUTPUT_QUEUES-1:0]  hdr_mask;
    logic [NUM_OUTPUT_QUEUES-1:0]  below_any;  // any mask bit set below position gi
    logic [NUM_OUTPUT_QUEUES-1:0]  first_hot;  // only the lowest set bit survives
    logic [NUM_OQ_WIDTH-1:0]       hdr_idx;
    logic                          hdr_mc;
    logic [DESC_W-1:0]             desc_in;
    logic                          unused_data_bits;

    assign hdr_mask = in_data[DST_PORT_POS +: NUM_OUTPUT_QUEUES];
    // Fields are sliced out of in_data; the reduction only marks the rest as intentionally ignored.
    assign unused_data_bits = ^in_data;

    generate
        for (genvar gi = 0; gi < NUM_OUTPUT_QUEUES; gi++) begin : g_lowest
            if (gi == 0) begin : g_first
                assign below_any[gi] = 1'b0;
            end else begin : g_rest
                assign below_any[gi] = below_any[gi-1] | hdr_mask[gi-1];
            end
            assign first_hot[gi] = hdr_mask[gi] & ~below_any[gi];
        end
    endgenerate

    // first_hot is one-hot or zero, so OR-ing indices is an exact encoder;
    // a zero mask naturally encodes to queue 0.
    always_comb begin
        hdr_idx = '0;
        for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
            if (first_hot[i]) begin
                hdr_idx = hdr_idx | NUM_OQ_WIDTH'(i);
            end
        end
    end

    // Multicast when any bit other than the lowest one is set.
    assign hdr_mc = |(hdr_mask & ~first_hot);

    assign desc_in = {in_data[WORD_LEN_POS +: PKT_WORD_CNT_WIDTH],
                      in_data[BYTE_LEN_POS +: PKT_BYTE_CNT_WIDTH],
                      hdr_mask, hdr_idx, hdr_mc};

    // ---------------- push / pop qualification ----------------
    logic is_hdr_word;
    logic hdr_seen;
    logic fifo_full;
    logic fifo_empty;
    logic push_ok;
    logic pop_ok;
    logic no_hdr_evt;
    logic overflow_evt;

    assign is_hdr_word  = (in_ctrl == IOQ_STAGE_NUM[CTRL_WIDTH-1:0]);
    assign hdr_seen     = in_wr && (state_reg == WAIT_HDR) && is_hdr_word;
    assign fifo_full    = (depth_reg == FULL_LVL);
    assign fifo_empty   = (depth_reg == '0);
    // Fullness is judged before any same-cycle pop, so a pop never makes room for a push.
    assign push_ok      = hdr_seen && !fifo_full;
    assign overflow_evt = hdr_seen && fifo_full;
    assign pop_ok       = rd_dst_oq && !fifo_empty;
    assign no_hdr_evt   = in_wr && (state_reg == WAIT_HDR) && (in_ctrl == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= WAIT_HDR;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            depth_reg        <= '0;
            err_no_hdr_reg   <= 1'b0;
            err_overflow_reg <= 1'b0;
        end else begin
            err_no_hdr_reg   <= no_hdr_evt;
            err_overflow_reg <= overflow_evt;

            if (in_wr) begin
                case (state_reg)
                    WAIT_HDR:  if (is_hdr_word)      state_reg <= WAIT_DATA;
                    WAIT_DATA: if (in_ctrl == '0)    state_reg <= WAIT_EOP;
                    WAIT_EOP:  if (in_ctrl != '0)    state_reg <= WAIT_HDR;
                    default:                         state_reg <= WAIT_HDR;
                endcase
            end

            if (push_ok) wr_ptr_reg <= wr_ptr_reg + FIFO_DEPTH_BITS'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + FIFO_DEPTH_BITS'(1);

            case ({push_ok, pop_ok})
                2'b10:   depth_reg <= depth_reg + (FIFO_DEPTH_BITS+1)'(1);
                2'b01:   depth_reg <= depth_reg - (FIFO_DEPTH_BITS+1)'(1);
                default: depth_reg <= depth_reg;
            endcase
        end
    end

    // Descriptor storage is not reset; occupancy gates every read below.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            desc_mem[wr_ptr_reg] <= desc_in;
        end
    end

`ifdef OQ_HDR_PARSER_ERR_CNT_EN
    logic [15:0] no_hdr_cnt_reg;
    logic [15:0] overflow_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            no_hdr_cnt_reg   <= '0;
            overflow_cnt_reg <= '0;
        end else begin
            if (no_hdr_evt && no_hdr_cnt_reg != 16'hFFFF)
                no_hdr_cnt_reg <= no_hdr_cnt_reg + 16'd1;
            if (overflow_evt && overflow_cnt_reg != 16'hFFFF)
                overflow_cnt_reg <= overflow_cnt_reg + 16'd1;
        end
    end

    assign no_hdr_cnt   = no_hdr_cnt_reg;
    assign overflow_cnt = overflow_cnt_reg;
`endif

    // ---------------- outputs ----------------
    // Asynchronous head read gives fall-through behaviour: a descriptor
    // written at one edge is visible right after it. Outputs read zero when empty.
    logic [DESC_W-1:0] head;
    assign head = fifo_empty ? '0 : desc_mem[rd_ptr_reg];

    assign {parsed_pkt_word_len, parsed_pkt_byte_len,
            parsed_dst_mask, parsed_dst_oq, parsed_multicast} = head;

    assign dst_oq_avail      = !fifo_empty;
    assign header_parser_rdy = !fifo_full;
    assign fifo_depth        = depth_reg;
    assign err_no_hdr        = err_no_hdr_reg;
    assign err_overflow      = err_overflow_reg;

endmodule

// File: tb/tb_oq_hdr_parser_mc.sv
// Self-checking bench for oq_hdr_parser_mc (default parameters).
// A queue-based reference model tracks the packet phase and the
// descriptor FIFO; every cycle the DUT outputs are compared against it.
module tb_oq_hdr_parser_mc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_wr = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [63:0] in_data = '0;
    logic        rd_dst_oq = 1'b0;
    logic        dst_oq_avail;
    logic        header_parser_rdy;
    logic [2:0]  parsed_dst_oq;
    logic [7:0]  parsed_dst_mask;
    logic        parsed_multicast;
    logic [10:0] parsed_pkt_byte_len;
    logic [7:0]  parsed_pkt_word_len;
    logic [3:0]  fifo_depth;
    logic        err_no_hdr;
    logic        err_overflow;
`ifdef OQ_HDR_PARSER_ERR_CNT_EN
    logic [15:0] no_hdr_cnt;
    logic [15:0] overflow_cnt;
`endif

    always #5 clk = ~clk;

    oq_hdr_parser_mc dut (
        .clk                 (clk),
        .reset               (reset),
        .in_wr               (in_wr),
        .in_ctrl             (in_ctrl),
        .in_data             (in_data),
        .rd_dst_oq           (rd_dst_oq),
        .dst_oq_avail        (dst_oq_avail),
        .header_parser_rdy   (header_parser_rdy),
        .parsed_dst_oq       (parsed_dst_oq),
        .parsed_dst_mask     (parsed_dst_mask),
        .parsed_multicast    (parsed_multicast),
        .parsed_pkt_byte_len (parsed_pkt_byte_len),
        .parsed_pkt_word_len (parsed_pkt_word_len),
        .fifo_depth          (fifo_depth),
`ifdef OQ_HDR_PARSER_ERR_CNT_EN
        .no_hdr_cnt          (no_hdr_cnt),
        .overflow_cnt        (overflow_cnt),
`endif
        .err_no_hdr          (err_no_hdr),
        .err_overflow        (err_overflow)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]  mask;
        logic [10:0] blen;
        logic [7:0]  wlen;
    } desc_t;

    desc_t q[$];
    int    phase = 0;          // 0: expecting header, 1: first data word, 2: until end of packet
    bit    exp_no_hdr = 0;
    bit    exp_ovf = 0;
    int    exp_nh_cnt = 0;
    int    exp_ov_cnt = 0;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest_queue(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [63:0] make_hdr(input logic [7:0] m, input logic [10:0] b, input logic [7:0] w);
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[55:48] = m;
        d[10:0]  = b;
        d[39:32] = w;
        return d;
    endfunction

    // One clock: drive inputs, advance the model, sample 1ns after the edge, compare.
    task automatic step(input logic rst, input logic wr, input logic [7:0] ctrl,
                        input logic [63:0] data, input logic rd);
        desc_t d;
        int    pre_size;
        reset = rst; in_wr = wr; in_ctrl = ctrl; in_data = data; rd_dst_oq = rd;

        if (rst) begin
            q.delete();
            phase = 0; exp_no_hdr = 0; exp_ovf = 0;
            exp_nh_cnt = 0; exp_ov_cnt = 0;
        end else begin
            pre_size   = q.size();
            exp_no_hdr = wr && phase == 0 && ctrl == 8'h00;
            exp_ovf    = wr && phase == 0 && ctrl == 8'hFF && pre_size == 8;
            if (exp_no_hdr && exp_nh_cnt < 65535) exp_nh_cnt++;
            if (exp_ovf && exp_ov_cnt < 65535) exp_ov_cnt++;
            if (rd && pre_size > 0) void'(q.pop_front());
            if (wr && phase == 0 && ctrl == 8'hFF && pre_size < 8) begin
                d.mask = data[55:48];
                d.blen = data[10:0];
                d.wlen = data[39:32];
                q.push_back(d);
            end
            if (wr) begin
                if (phase == 0 && ctrl == 8'hFF)      phase = 1;
                else if (phase == 1 && ctrl == 8'h00) phase = 2;
                else if (phase == 2 && ctrl != 8'h00) phase = 0;
            end
        end

        @(posedge clk);
        #1;
        $display("txn rst=%0b wr=%0b ctrl=%02h rd=%0b -> depth=%0d avail=%0b oq=%0d mask=%02h mc=%0b nohdr=%0b ovf=%0b",
                 rst, wr, ctrl, rd, fifo_depth, dst_oq_avail, parsed_dst_oq, parsed_dst_mask,
                 parsed_multicast, err_no_hdr, err_overflow);
        check_eq("fifo_depth", 32'(fifo_depth), q.size());
        check_eq("dst_oq_avail", 32'(dst_oq_avail), 32'(q.size() > 0));
        check_eq("header_parser_rdy", 32'(header_parser_rdy), 32'(q.size() < 8));
        check_eq("err_no_hdr", 32'(err_no_hdr), 32'(exp_no_hdr));
        check_eq("err_overflow", 32'(err_overflow), 32'(exp_ovf));
`ifdef OQ_HDR_PARSER_ERR_CNT_EN
        check_eq("no_hdr_cnt", 32'(no_hdr_cnt), exp_nh_cnt);
        check_eq("overflow_cnt", 32'(overflow_cnt), exp_ov_cnt);
`endif
        if (q.size() > 0) begin
            d = q[0];
            check_eq("parsed_dst_mask", 32'(parsed_dst_mask), 32'(d.mask));
            check_eq("parsed_dst_oq", 32'(parsed_dst_oq), lowest_queue(d.mask));
            check_eq("parsed_multicast", 32'(parsed_multicast), 32'($countones(d.mask) > 1));
            check_eq("parsed_byte_len", 32'(parsed_pkt_byte_len), 32'(d.blen));
            check_eq("parsed_word_len", 32'(parsed_pkt_word_len), 32'(d.wlen));
        end else if (rst) begin
            check_eq("reset_parsed_fields",
                     {5'd0, parsed_dst_oq, parsed_dst_mask, parsed_multicast, parsed_pkt_byte_len, 4'd0},
                     32'd0);
            check_eq("reset_word_len", 32'(parsed_pkt_word_len), 32'd0);
        end
    endtask

    task automatic pkt(input logic [7:0] m, input logic [10:0] b, input logic [7:0] w);
        step(0, 1, 8'hFF, make_hdr(m, b, w), 0);
        step(0, 1, 8'h00, {$urandom, $urandom}, 0);
        step(0, 1, 8'h01, {$urandom, $urandom}, 0);
    endtask

    initial begin
        logic [7:0]  m;
        logic [7:0]  c;
        logic [63:0] d;
        int          r;

        // Reset state
        step(1, 0, 8'h00, 64'd0, 0);
        step(1, 0, 8'h00, 64'd0, 0);
        check_eq("reset_rdy", 32'(header_parser_rdy), 32'd1);

        // Unicast header: next cycle shows the descriptor
        step(0, 1, 8'hFF, make_hdr(8'h10, 11'd60, 8'd8), 0);
        check_eq("uc_avail", 32'(dst_oq_avail), 32'd1);
        check_eq("uc_oq", 32'(parsed_dst_oq), 32'd4);
        check_eq("uc_mc", 32'(parsed_multicast), 32'd0);
        check_eq("uc_blen", 32'(parsed_pkt_byte_len), 32'd60);
        check_eq("uc_wlen", 32'(parsed_pkt_word_len), 32'd8);
        step(0, 1, 8'h00, 64'd0, 0);
        step(0, 1, 8'h01, 64'd0, 1);

        // Multicast header
        pkt(8'h24, 11'd128, 8'd16);
        check_eq("mc_oq", 32'(parsed_dst_oq), 32'd2);
        check_eq("mc_mc", 32'(parsed_multicast), 32'd1);
        check_eq("mc_mask", 32'(parsed_dst_mask), 32'h24);

        // Zero mask passes through as queue 0, not multicast
        step(0, 0, 8'h00, 64'd0, 1);
        pkt(8'h00, 11'd64, 8'd8);
        check_eq("zero_mask_oq", 32'(parsed_dst_oq), 32'd0);
        check_eq("zero_mask_mc", 32'(parsed_multicast), 32'd0);

        // Data word while waiting for a header
        step(1, 0, 8'h00, 64'd0, 0);
        step(0, 1, 8'h00, 64'd0, 0);
        check_eq("nohdr_pulse", 32'(err_no_hdr), 32'd1);
        check_eq("nohdr_depth", 32'(fifo_depth), 32'd0);
        step(0, 0, 8'h00, 64'd0, 0);
        check_eq("nohdr_pulse_end", 32'(err_no_hdr), 32'd0);

        // Fill to full, then overflow
        step(1, 0, 8'h00, 64'd0, 0);
        for (int i = 0; i < 8; i++) pkt(8'(1 << i), 11'(100 + i), 8'(13 + i));
        check_eq("full_rdy", 32'(header_parser_rdy), 32'd0);
        step(0, 1, 8'hFF, make_hdr(8'h80, 11'd999, 8'd99), 1'b0);
        check_eq("ovf_pulse", 32'(err_overflow), 32'd1);
        check_eq("ovf_depth", 32'(fifo_depth), 32'd8);
        // Pop while full and a header arrives in the same cycle: header still dropped
        step(0, 1, 8'h00, 64'd0, 0);
        check_eq("ovf_pulse_end", 32'(err_overflow), 32'd0);
        step(0, 1, 8'h01, 64'd0, 0);
        step(0, 1, 8'hFF, make_hdr(8'h03, 11'd5, 8'd1), 1'b1);
        check_eq("full_pop_push_ovf", 32'(err_overflow), 32'd1);

        // Simultaneous push and pop at depth 3
        step(1, 0, 8'h00, 64'd0, 0);
        pkt(8'h01, 11'd10, 8'd2);
        pkt(8'h02, 11'd20, 8'd3);
        pkt(8'h04, 11'd30, 8'd4);
        step(0, 1, 8'hFF, make_hdr(8'h08, 11'd40, 8'd5), 1);
        check_eq("pushpop_depth", 32'(fifo_depth), 32'd3);
        check_eq("pushpop_head", 32'(parsed_dst_mask), 32'h02);

        // Reset mid-packet with two descriptors queued
        step(1, 0, 8'h00, 64'd0, 0);
        pkt(8'h01, 11'd10, 8'd2);
        step(0, 1, 8'hFF, make_hdr(8'h40, 11'd50, 8'd7), 0);
        step(0, 1, 8'h00, 64'd0, 0);
        step(1, 1, 8'h00, 64'd0, 0);
        check_eq("rst_mid_avail", 32'(dst_oq_avail), 32'd0);
        check_eq("rst_mid_depth", 32'(fifo_depth), 32'd0);
        step(0, 1, 8'hFF, make_hdr(8'h20, 11'd77, 8'd9), 0);
        check_eq("rst_mid_accept", 32'(fifo_depth), 32'd1);
        check_eq("rst_mid_oq", 32'(parsed_dst_oq), 32'd5);

        // Randomised traffic against the model
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 3);
            c = (r == 0) ? 8'h00 : (r == 3) ? 8'(($urandom_range(1, 254))) : 8'hFF;
            r = $urandom_range(0, 3);
            m = (r == 0) ? 8'h00 : (r == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            d = make_hdr(m, 11'($urandom), 8'($urandom));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), c, d,
                 ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
